mesi_snoop_responder: RTL

//   Snoop-side half of the per-core MESI controller. Accepts bus/directory snoops (BusRd, BusRdX, BusUpgr)

---
 rtl/mesi_snoop_responder_if.sv | 29 ++
 rtl/mesi_snoop_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_responder_if.sv
// Snoop request and snoop response channels between the coherence bus/directory and one core's responder.
// The bus side is the master: it drives requests and accepts response beats.
interface mesi_snoop_responder_if #(
    parameter int ADDR_W = 32
);
    logic              snp_valid;
    logic              snp_ready;
    logic [1:0]        snp_type;
    logic [ADDR_W-1:0] snp_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_shared;
    logic              rsp_dirty;
    logic              rsp_err;
    logic [31:0]       rsp_data;
    logic              rsp_last;

    modport master (
        output snp_valid, snp_type, snp_addr, rsp_ready,
        input  snp_ready, rsp_valid, rsp_hit, rsp_shared, rsp_dirty, rsp_err, rsp_data, rsp_last
    );

    modport slave (
        input  snp_valid, snp_type, snp_addr, rsp_ready,
        output snp_ready, rsp_valid, rsp_hit, rsp_shared, rsp_dirty, rsp_err, rsp_data, rsp_last
    );
endinterface

// File: rtl/mesi_snoop_responder.sv
// MESI snoop responder: tag lookup, downgrade/invalidate write, single-beat reply or 4-beat flush of M lines.
// Reply at T+3 (flush beat k at T+4+2k, reserved type at T+1); each beat held until rsp_ready, no accept while busy.
module mesi_snoop_responder #(
    parameter int CACHE_LINES = 64,
    parameter int INDEX_W     = $clog2(CACHE_LINES),
    parameter int ADDR_W      = 32,
    parameter int TAG_W       = ADDR_W - INDEX_W - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mesi_snoop_responder_if.slave bus,
    input  logic                  core_lock,
    output logic                  snp_busy,
    output logic [INDEX_W-1:0]    snp_idx,
    output logic                  tag_rd_en,
    output logic [INDEX_W-1:0]    tag_rd_idx,
    input  logic [TAG_W-1:0]      tag_rd_tag,
    input  logic [1:0]            tag_rd_state,
    output logic                  st_wr_en,
    output logic [INDEX_W-1:0]    st_wr_idx,
    output logic [1:0]            st_wr_state,
    output logic                  dat_rd_en,
    output logic [INDEX_W-1:0]    dat_rd_idx,
    output logic [1:0]            dat_rd_word,
    input  logic [31:0]           dat_rd_data
);
    localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;
    localparam logic [1:0] BUS_RD = 2'b00, BUS_UPGR = 2'b10, BUS_RSVD = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVAL, RESP, FLUSH_RD, FLUSH_TX} state_t;

    state_t           state;
    logic             live;
    logic             tx_first;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       type_q;
    logic [1:0]       word;
    logic [31:0]      data_q;
    logic             rsp_valid_q, rsp_hit_q, rsp_shared_q, rsp_dirty_q, rsp_err_q, rsp_last_q;
    logic             ready, accept, line_hit, line_dirty;
    logic             unused_ok;

    // live keeps snp_ready low while reset is held and for the edge that releases it
    assign ready      = live & (state == IDLE) & ~core_lock;
    assign accept     = bus.snp_valid & ready;
    assign line_hit   = (tag_rd_state != ST_I) && (tag_rd_tag == tag_q);
    assign line_dirty = line_hit && (tag_rd_state == ST_M);
    assign unused_ok  = ^bus.snp_addr[3:0];

    assign bus.snp_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_shared = rsp_shared_q;
    assign bus.rsp_dirty  = rsp_dirty_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_last   = rsp_last_q;
    // Read data lands the same cycle the beat goes valid, so the first TX cycle bypasses the holding register.
    assign bus.rsp_data   = (state == FLUSH_TX) ? (tx_first ? dat_rd_data : data_q) : 32'd0;

    assign tag_rd_idx  = snp_idx;
    assign st_wr_idx   = snp_idx;
    assign dat_rd_idx  = snp_idx;
    assign dat_rd_word = word;

    // The state write depends on the tag read returning in EVAL, so it cannot be registered.
    always_comb begin
        st_wr_en    = 1'b0;
        st_wr_state = 2'b00;
        if (state == EVAL && line_hit) begin
            st_wr_en    = (type_q != BUS_RD) || (tag_rd_state != ST_S);
            st_wr_state = (type_q == BUS_RD) ? ST_S : ST_I;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            live         <= 1'b0;
            tx_first     <= 1'b0;
            snp_busy     <= 1'b0;
            snp_idx      <= '0;
            tag_q        <= '0;
            type_q       <= 2'b00;
            word         <= 2'd0;
            data_q       <= 32'd0;
            tag_rd_en    <= 1'b0;
            dat_rd_en    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_shared_q <= 1'b0;
            rsp_dirty_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_last_q   <= 1'b0;
        end else begin
            live      <= 1'b1;
            tag_rd_en <= 1'b0;
            dat_rd_en <= 1'b0;
            tx_first  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    snp_idx  <= bus.snp_addr[INDEX_W+3:4];
                    tag_q    <= bus.snp_addr[ADDR_W-1:INDEX_W+4];
                    type_q   <= bus.snp_type;
                    snp_busy <= 1'b1;
                    if (bus.snp_type == BUS_RSVD) begin
                        state        <= RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_hit_q    <= 1'b0;
                        rsp_shared_q <= 1'b0;
                        rsp_dirty_q  <= 1'b0;
                        rsp_err_q    <= 1'b1;
                        rsp_last_q   <= 1'b1;
                    end else begin
                        state     <= LOOKUP;
                        tag_rd_en <= 1'b1;
                    end
                end
                LOOKUP: state <= EVAL;
                EVAL: begin
                    word         <= 2'd0;
                    rsp_hit_q    <= line_hit;
                    rsp_shared_q <= line_hit && (type_q == BUS_RD);
                    rsp_err_q    <= line_hit && (type_q == BUS_UPGR) &&
                                    (tag_rd_state == ST_M || tag_rd_state == ST_E);
                    if (line_dirty) begin
                        state     <= FLUSH_RD;
                        dat_rd_en <= 1'b1;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_dirty_q <= 1'b0;
                        rsp_last_q  <= 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state        <= IDLE;
                    snp_busy     <= 1'b0;
                    rsp_valid_q  <= 1'b0;
                    rsp_hit_q    <= 1'b0;
                    rsp_shared_q <= 1'b0;
                    rsp_err_q    <= 1'b0;
                    rsp_last_q   <= 1'b0;
                end
                FLUSH_RD: begin
                    state       <= FLUSH_TX;
                    tx_first    <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_dirty_q <= 1'b1;
                    rsp_last_q  <= (word == 2'd3);
                end
                FLUSH_TX: begin
                    if (tx_first) data_q <= dat_rd_data;
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (word == 2'd3) begin
                            state        <= IDLE;
                            snp_busy     <= 1'b0;
                            word         <= 2'd0;
                            rsp_hit_q    <= 1'b0;
                            rsp_shared_q <= 1'b0;
                            rsp_dirty_q  <= 1'b0;
                            rsp_err_q    <= 1'b0;
                            rsp_last_q   <= 1'b0;
                        end else begin
                            state     <= FLUSH_RD;
                            word      <= word + 2'd1;
                            dat_rd_en <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
